// File: rtl/i2s_clock_gen.sv
// I2S serial timing from Clk50: free-running MCLK divider, fractional-accumulator SClk,
// LRClk/bit sequencing on falling SClk, and a per-stereo-frame tick with a wrapping frame counter.

module i2s_clock_gen_param_check #(
    parameter int ACC_W    = 24,
    parameter int INC      = 2061584,
    parameter int MCLK_DIV = 4
) ();
    // An increment of half the accumulator range or more could toggle SClk on back-to-back edges.
    if (64'(INC) >= (64'd1 << (ACC_W - 1))) begin : g_inc_too_large
        $error("i2s_clock_gen: INC must be below 2^(ACC_W-1)");
    end
    if ((MCLK_DIV < 2) || ((MCLK_DIV % 2) != 0)) begin : g_mclk_div_bad
        $error("i2s_clock_gen: MCLK_DIV must be even and at least 2");
    end
endmodule

module i2s_clock_gen #(
    parameter int ACC_W    = 24,
    parameter int INC      = 2061584,
    parameter int MCLK_DIV = 4
) (
    input  logic        Clk50,
    input  logic        reset_n,
    input  logic        en,
    output logic        MCLK,
    output logic        SClk,
    output logic        LRClk,
    output logic [4:0]  bit_cnt,
    output logic        sample_tick,
    output logic [15:0] frame_cnt
);
    localparam int HALF_DIV = MCLK_DIV / 2;
    localparam int DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [ACC_W:0]   INC_EXT  = (ACC_W + 1)'(INC);

    logic [DIV_W-1:0] mclk_div_r;
    logic             mclk_r;
    logic [ACC_W-1:0] acc_r;
    logic             sclk_r;
    logic             lrclk_r;
    logic [4:0]       bit_cnt_r;
    logic             sample_tick_r;
    logic [15:0]      frame_cnt_r;

    logic [ACC_W:0]   sum_s;
    logic             carry_s;
    logic             sclk_fall_s;
    logic             half_end_s;

    i2s_clock_gen_param_check #(
        .ACC_W    (ACC_W),
        .INC      (INC),
        .MCLK_DIV (MCLK_DIV)
    ) u_param_check ();

    // Accumulator step and the bit-clock events it produces this edge.
    always_comb begin
        sum_s       = {1'b0, acc_r} + INC_EXT;
        carry_s     = sum_s[ACC_W];
        sclk_fall_s = carry_s & sclk_r;
        half_end_s  = sclk_fall_s & (bit_cnt_r == 5'd31);
    end

    // MCLK divider: runs whenever out of reset, independent of en.
    always_ff @(posedge Clk50) begin
        if (!reset_n) begin
            mclk_div_r <= '0;
            mclk_r     <= 1'b0;
        end else if (mclk_div_r == DIV_LAST) begin
            mclk_div_r <= '0;
            mclk_r     <= ~mclk_r;
        end else begin
            mclk_div_r <= mclk_div_r + DIV_ONE;
        end
    end

    // Bit clock, word select, bit index, frame tick and frame counter.
    always_ff @(posedge Clk50) begin
        if (!reset_n) begin
            acc_r         <= '0;
            sclk_r        <= 1'b0;
            lrclk_r       <= 1'b0;
            bit_cnt_r     <= 5'd0;
            sample_tick_r <= 1'b0;
            frame_cnt_r   <= 16'd0;
        end else if (!en) begin
            // Idle abandons any partial frame; frame_cnt keeps its count.
            acc_r         <= '0;
            sclk_r        <= 1'b0;
            lrclk_r       <= 1'b0;
            bit_cnt_r     <= 5'd0;
            sample_tick_r <= 1'b0;
        end else begin
            acc_r         <= sum_s[ACC_W-1:0];
            sample_tick_r <= 1'b0;
            if (carry_s) begin
                sclk_r <= ~sclk_r;
            end
            if (sclk_fall_s) begin
                bit_cnt_r <= bit_cnt_r + 5'd1;
            end
            if (half_end_s) begin
                lrclk_r <= ~lrclk_r;
                if (!lrclk_r) begin
                    sample_tick_r <= 1'b1;
                    frame_cnt_r   <= frame_cnt_r + 16'd1;
                end
            end
        end
    end

    assign MCLK        = mclk_r;
    assign SClk        = sclk_r;
    assign LRClk       = lrclk_r;
    assign bit_cnt     = bit_cnt_r;
    assign sample_tick = sample_tick_r;
    assign frame_cnt   = frame_cnt_r;
endmodule
